// File: rtl/enc_pkg.sv
// Shared types and widths for the 16-request priority encoder block.
package enc_pkg;

    localparam int REQ_W  = 16;
    localparam int CODE_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/priority_encoder_16x4.sv
// Combinational priority encoder: index of the lowest (or highest) set bit plus an any-set flag.
module priority_encoder_16x4
    import enc_pkg::*;
#(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic [REQ_W-1:0]  vec,
    output logic [CODE_W-1:0] index,
    output logic              found
);

    // NOTE: every output gets a default before the scan, so no latch is inferred.
    always_comb begin
        index = '0;
        found = |vec;
        if (LOW_FIRST) begin
            // Later (lower) hits overwrite earlier ones, so the lowest set bit wins.
            for (int i = REQ_W - 1; i >= 0; i--) begin
                if (vec[i]) index = CODE_W'(i);
            end
        end else begin
            for (int i = 0; i < REQ_W; i++) begin
                if (vec[i]) index = CODE_W'(i);
            end
        end
    end

endmodule

// File: rtl/request_encoder_16x4.sv
// Captures a request vector and drains it one index per handshake in priority order.
module request_encoder_16x4
    import enc_pkg::*;
#(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REQ_W-1:0]  req,
    input  logic              load,
    input  logic              abort,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] code,
    output logic              done,
    output logic              none
);

    state_t              state;
    logic [REQ_W-1:0]    pending;
    logic [REQ_W-1:0]    remaining;
    logic [REQ_W-1:0]    enc_in;
    logic [CODE_W-1:0]   next_code;
    logic                next_any;

    // One encoder serves both capture (raw req) and drain (pending minus the reported bit).
    assign remaining = pending & ~(REQ_W'(1) << code);
    assign enc_in    = (state == IDLE) ? req : remaining;

    priority_encoder_16x4 #(
        .LOW_FIRST (LOW_FIRST)
    ) u_prio (
        .vec   (enc_in),
        .index (next_code),
        .found (next_any)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            code      <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            none      <= 1'b0;
        end else begin
            done <= 1'b0;
            none <= 1'b0;
            case (state)
                IDLE: begin
                    if (load && !abort) begin
                        if (next_any) begin
                            pending   <= req;
                            code      <= next_code;
                            out_valid <= 1'b1;
                            busy      <= 1'b1;
                            state     <= EMIT;
                        end else begin
                            none <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    // out_valid is always high here, so out_ready alone marks a handshake.
                    if (abort) begin
                        pending   <= '0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (out_ready) begin
                        if (next_any) begin
                            pending <= remaining;
                            code    <= next_code;
                        end else begin
                            pending   <= '0;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_request_encoder_16x4.sv
// Self-checking bench: runs both scan orders side by side against a queue-based model.
module tb_request_encoder_16x4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = '0;
    logic        load = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;

    logic        busy_lo, out_valid_lo, done_lo, none_lo;
    logic [3:0]  code_lo;
    logic        busy_hi, out_valid_hi, done_hi, none_hi;
    logic [3:0]  code_hi;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    request_encoder_16x4 #(.LOW_FIRST(1'b1)) dut_lo (
        .clk(clk), .rst(rst), .req(req), .load(load), .abort(abort),
        .busy(busy_lo), .out_valid(out_valid_lo), .out_ready(out_ready),
        .code(code_lo), .done(done_lo), .none(none_lo)
    );

    request_encoder_16x4 #(.LOW_FIRST(1'b0)) dut_hi (
        .clk(clk), .rst(rst), .req(req), .load(load), .abort(abort),
        .busy(busy_hi), .out_valid(out_valid_hi), .out_ready(out_ready),
        .code(code_hi), .done(done_hi), .none(none_hi)
    );

    // Status of both instances packed as {valid, busy, done, none} x {lo, hi}.
    function automatic logic [7:0] status();
        return {out_valid_lo, busy_lo, done_lo, none_lo,
                out_valid_hi, busy_hi, done_hi, none_hi};
    endfunction

    // Drain one vector. Called at a negedge; returns at the negedge after the drain ends.
    // mode: 0 = always ready, 1 = random ready, 2 = ready low for the first 3 cycles.
    // abort_after: handshake count at which abort is raised together with the handshake (0 = never).
    task automatic drain(input logic [15:0] v, input int mode, input int abort_after, input string tag);
        int  q_lo[$];
        int  q_hi[$];
        int  hs = 0;
        int  cyc = 0;
        int  busy_cyc = 0;
        int  total;
        bit  aborted = 0;
        bit  fin = 0;
        bit  ready;
        for (int i = 0; i < 16; i++) if (v[i]) q_lo.push_back(i);
        for (int i = 15; i >= 0; i--) if (v[i]) q_hi.push_back(i);
        total = q_lo.size();
        load = 1'b1; req = v; abort = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        load = 1'b0;
        while (!fin) begin
            checks++;
            if (status() !== 8'b1100_1100) begin
                failures++;
                $display("FAIL %s_status cyc=%0d got=%b exp=11001100", tag, cyc, status());
            end
            if (busy_lo) busy_cyc++;
            checks++;
            if (code_lo !== 4'(q_lo[0]) || code_hi !== 4'(q_hi[0])) begin
                failures++;
                $display("FAIL %s_code cyc=%0d got lo=%0d hi=%0d exp lo=%0d hi=%0d",
                         tag, cyc, code_lo, code_hi, q_lo[0], q_hi[0]);
            end
            case (mode)
                0:       ready = 1'b1;
                2:       ready = (cyc >= 3);
                default: ready = 1'($urandom_range(0, 1));
            endcase
            out_ready = ready;
            load = 1'($urandom_range(0, 1));
            req = 16'($urandom);
            if (ready) begin
                void'(q_lo.pop_front());
                void'(q_hi.pop_front());
                hs++;
                if (hs == abort_after) begin
                    abort = 1'b1;
                    aborted = 1'b1;
                end
                if (aborted || q_lo.size() == 0) fin = 1;
            end
            @(negedge clk);
            abort = 1'b0; out_ready = 1'b0; load = 1'b0;
            cyc++;
            if (cyc > 200) begin
                failures++;
                $display("FAIL %s_timeout cycles=%0d", tag, cyc);
                fin = 1;
            end
        end
        checks++;
        if (status() !== (aborted ? 8'b0000_0000 : 8'b0010_0010)) begin
            failures++;
            $display("FAIL %s_end got=%b exp=%b", tag, status(),
                     aborted ? 8'b0000_0000 : 8'b0010_0010);
        end
        if (mode == 0 && !aborted) begin
            checks++;
            if (busy_cyc != total) begin
                failures++;
                $display("FAIL %s_busy_cycles got=%0d exp=%0d", tag, busy_cyc, total);
            end
        end
        @(negedge clk);
        checks++;
        if (status() !== 8'b0000_0000) begin
            failures++;
            $display("FAIL %s_after got=%b exp=00000000", tag, status());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (status() !== 8'b0 || code_lo !== 4'd0 || code_hi !== 4'd0) begin
            failures++;
            $display("FAIL reset got=%b codes=%0d/%0d exp=00000000 codes=0/0", status(), code_lo, code_hi);
        end
        rst = 1'b0;
    endtask

    task automatic test_order();
        drain(16'h8421, 0, 0, "order_8421");
    endtask

    task automatic test_stall();
        drain(16'h0003, 2, 0, "stall_0003");
    endtask

    task automatic test_none();
        load = 1'b1; req = 16'h0000;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (status() !== 8'b0001_0001) begin
            failures++;
            $display("FAIL none_pulse got=%b exp=00010001", status());
        end
        @(negedge clk);
        checks++;
        if (status() !== 8'b0000_0000) begin
            failures++;
            $display("FAIL none_clear got=%b exp=00000000", status());
        end
    endtask

    task automatic test_abort();
        drain(16'hFFFF, 0, 2, "abort_ffff");
        // Abort beats a simultaneous load, both for a real vector and an empty one.
        load = 1'b1; abort = 1'b1; req = 16'hFFFF;
        @(negedge clk);
        checks++;
        if (status() !== 8'b0000_0000) begin
            failures++;
            $display("FAIL abort_load got=%b exp=00000000", status());
        end
        req = 16'h0000;
        @(negedge clk);
        load = 1'b0; abort = 1'b0;
        checks++;
        if (status() !== 8'b0000_0000) begin
            failures++;
            $display("FAIL abort_load_zero got=%b exp=00000000", status());
        end
    endtask

    task automatic test_reset_mid_drain();
        load = 1'b1; req = 16'h00F0; out_ready = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        checks++;
        if (code_lo !== 4'd5 || code_hi !== 4'd6 || status() !== 8'b1100_1100) begin
            failures++;
            $display("FAIL mid_drain_pre got codes=%0d/%0d st=%b exp codes=5/6 st=11001100",
                     code_lo, code_hi, status());
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (status() !== 8'b0 || code_lo !== 4'd0 || code_hi !== 4'd0) begin
            failures++;
            $display("FAIL async_reset got=%b codes=%0d/%0d exp=00000000 codes=0/0",
                     status(), code_lo, code_hi);
        end
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        drain(16'h0100, 0, 0, "post_reset_0100");
    endtask

    task automatic test_random();
        logic [15:0] v;
        for (int n = 0; n < 40; n++) begin
            v = 16'($urandom) & 16'($urandom_range(0, 1) ? 16'hFFFF : $urandom);
            if (v == 16'h0) v = 16'h0001 << $urandom_range(0, 15);
            drain(v, 1, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, "random");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_order();
        test_stall();
        test_none();
        test_abort();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
